cache_fill_fsm: RTL

Miss-handling controller between the L1 cache arrays (instruction or data side) and the shared multi-cycle main memory. On a cache miss it fetches one whole block from memory with pipelined word reads. It writes each returned word into the data array and commits the tag when the last word arrives. While the fill is in progress it stalls the processor through fsm_busy.

---
 rtl/cache_fill_fsm.sv | 102 ++++++++++
 1 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller with pipelined word reads
module cache_fill_fsm #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_word_addr,
    output logic              write_tag_array
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] BW_CNT   = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rx_cnt;

    logic [ADDR_W-1:0] base_next;
    logic              issue_done;
    logic              last_rx;
    logic [IDX_W-1:0]  issue_idx;
    logic              unused_low_bits;

    // Word offsets are spliced into the block base, so addresses never carry out of the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] b,
                                                    input logic [IDX_W-1:0]  idx);
        return {b[ADDR_W-1:OFF_W], idx, 1'b0};
    endfunction

    assign base_next       = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign issue_done      = (issue_cnt >= BW_CNT);
    assign issue_idx       = issue_done ? LAST_IDX : issue_cnt[IDX_W-1:0];
    assign last_rx         = memory_data_valid && (rx_cnt == LAST_CNT);
    assign unused_low_bits = ^{miss_address[OFF_W-1:0], base[OFF_W-1:0]};

    always_comb begin
        mem_read_en      = 1'b0;
        memory_address   = base_next;
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        fill_word_addr   = word_addr(base, rx_cnt[IDX_W-1:0]);
        if (state == IDLE) begin
            mem_read_en = miss_detected;
            fsm_busy    = miss_detected;
        end else begin
            fsm_busy         = 1'b1;
            mem_read_en      = !issue_done;
            memory_address   = word_addr(base, issue_idx);
            write_data_array = memory_data_valid;
            write_tag_array  = last_rx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base      <= base_next;
                        issue_cnt <= CNT_W'(1);
                        rx_cnt    <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (!issue_done)
                        issue_cnt <= issue_cnt + 1'b1;
                    if (memory_data_valid) begin
                        if (last_rx) begin
                            rx_cnt    <= '0;
                            issue_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
